// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester handshakes, result registers and ALU drive/return bus
// for the two-port ALU arbiter. The slave modport is the arbiter. The master
// modport is its environment: both requesters and the ALU instance.
interface alu_arbiter_if;
  // requester side
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;          // {AINV, BNEG, Opr[1:0]}
  logic        ack0, ack1;
  logic        done0, done1;
  logic [31:0] res_result;
  logic        res_zero, res_overflow, res_cout;
  logic        busy;
  // ALU side
  logic [31:0] alu_a, alu_b;
  logic        alu_ainv, alu_bneg;
  logic [1:0]  alu_opr;
  logic [31:0] alu_result;
  logic        alu_zero, alu_overflow, alu_cout;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1,
    input  alu_result, alu_zero, alu_overflow, alu_cout,
    output ack0, ack1, done0, done1,
    output res_result, res_zero, res_overflow, res_cout, busy,
    output alu_a, alu_b, alu_ainv, alu_bneg, alu_opr
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1,
    output alu_result, alu_zero, alu_overflow, alu_cout,
    input  ack0, ack1, done0, done1,
    input  res_result, res_zero, res_overflow, res_cout, busy,
    input  alu_a, alu_b, alu_ainv, alu_bneg, alu_opr
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ripple ALU between two requesters.
// A grant loads the winner's operands into the ALU-drive registers for one BUSY
// cycle, which is the ALU's settle window. The result and flags are captured at
// the end of that cycle, and DONE pulses for the granted port.
// Build option: ALU_ARB_FIXED_PRIO_EN gives fixed priority, so port 0 wins ties.
// Without it (the default), ties are round-robin on LAST_GNT.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]      state;
  logic            gnt;       // port that owns the current BUSY cycle
  logic            win;       // arbitration winner among present requests
  logic            grant;
  logic            complete;
  logic [1:0]      req;
  logic [1:0][31:0] a_in, b_in;
  logic [1:0][3:0]  op_in;
  logic [1:0]      ack, done;

  assign req   = {bus.req1, bus.req0};
  assign a_in  = {bus.a1, bus.a0};
  assign b_in  = {bus.b1, bus.b0};
  assign op_in = {bus.op1, bus.op0};

  assign grant    = (state == IDLE) && (|req);
  assign complete = (state == BUSY);

`ifdef ALU_ARB_FIXED_PRIO_EN
  // port 0 wins whenever it is requesting
  always_comb win = ~req[0];
`else
  logic last_gnt;

  // tie goes to the port not granted last; a lone request wins outright
  always_comb begin
    win = req[1];
    if (&req) win = ~last_gnt;
  end

  // remember the last granted port; reset value 1 hands port 0 the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_gnt <= 1'b1;
    else if (grant) last_gnt <= win;
  end
`endif

  // sequencer: IDLE grants and loads ALU drive regs, BUSY captures the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      gnt              <= 1'b0;
      bus.alu_a        <= '0;
      bus.alu_b        <= '0;
      bus.alu_ainv     <= 1'b0;
      bus.alu_bneg     <= 1'b0;
      bus.alu_opr      <= 2'b00;
      bus.res_result   <= '0;
      bus.res_zero     <= 1'b0;
      bus.res_overflow <= 1'b0;
      bus.res_cout     <= 1'b0;
    end else if (grant) begin
      state        <= BUSY;
      gnt          <= win;
      bus.alu_a    <= a_in[win];
      bus.alu_b    <= b_in[win];
      bus.alu_ainv <= op_in[win][3];
      bus.alu_bneg <= op_in[win][2];
      bus.alu_opr  <= op_in[win][1:0];
    end else if (complete) begin
      state            <= IDLE;
      bus.res_result   <= bus.alu_result;
      bus.res_zero     <= bus.alu_zero;
      bus.res_overflow <= bus.alu_overflow;
      bus.res_cout     <= bus.alu_cout;
    end
  end

  // per-port handshake: ACK covers the BUSY cycle, DONE marks the cycle after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack  <= '0;
      done <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        done[i] <= complete && (gnt == 1'(i));
        if (grant && (win == 1'(i))) ack[i] <= 1'b1;
        else if (complete)           ack[i] <= 1'b0;
      end
    end
  end

  assign bus.ack0  = ack[0];
  assign bus.ack1  = ack[1];
  assign bus.done0 = done[0];
  assign bus.done1 = done[1];
  assign bus.busy  = (state == BUSY);
endmodule
